snoopy_bus_arbiter: RTL and testbench

Token-based arbiter and sequencer for the shared snoop bus in the dual-core system. Accepts coherence requests (read or write-invalidate) from both L1 caches and grants one at a time. Forwards the winner's request to the other cache's snoop port, waits for that cache's snoop response, and returns hit and data to the requester. Sits between the two cache controllers' request/update ports and the snoop ports.

---
 rtl/snoopy_pkg.sv | 8 +
 rtl/snoopy_token_rr.sv | 17 +
 rtl/snoopy_bus_arbiter.sv | 116 +++++++++++
 tb/tb_snoopy_bus_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snoopy_pkg.sv
// snoopy_pkg: shared types and constants for the snoop bus arbiter
package snoopy_pkg;
  typedef enum logic [1:0] {IDLE, SNOOP, RESP} state_t;
  typedef logic core_id_t;
  localparam int NUM_CORES = 2;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/snoopy_token_rr.sv
// snoopy_token_rr: combinational 2-way token arbiter; token register lives in the parent
module snoopy_token_rr
  import snoopy_pkg::*;
(
  input  logic [NUM_CORES-1:0] req,
  input  logic                 token,
  input  logic                 advance,
  output logic                 grant_id,
  output logic                 grant_valid,
  output logic                 token_nxt
);
  always_comb begin
    grant_id = req[token] ? token : ~token;
    grant_valid = |req;
    token_nxt = advance ? ~grant_id : token;
  end
endmodule

// File: rtl/snoopy_bus_arbiter.sv
// snoopy_bus_arbiter: token arbiter and sequencer for the dual-core snoop bus
// Define SNOOPY_TIMEOUT_EN to abort snoops that see no ack within TIMEOUT_CYCLES.
module snoopy_bus_arbiter
  import snoopy_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req_valid_i,
  input  logic [NUM_CORES-1:0]        req_wnr_i,
  input  logic [NUM_CORES*ADDR_W-1:0] req_addr_i,
  output logic [NUM_CORES-1:0]        req_ack_o,
  output logic                        rsp_hit_o,
  output logic [DATA_W-1:0]           rsp_data_o,
  output logic [NUM_CORES-1:0]        snp_valid_o,
  output logic                        snp_wnr_o,
  output logic [ADDR_W-1:0]           snp_addr_o,
  input  logic [NUM_CORES-1:0]        snp_ack_i,
  input  logic [NUM_CORES-1:0]        snp_hit_i,
  input  logic [NUM_CORES*DATA_W-1:0] snp_data_i,
  output logic                        token_o,
  output logic                        busy_o,
  output logic                        timeout_o
);
  state_t state, state_nxt;
  core_id_t winner, other, grant_id, token, token_nxt;
  logic grant_valid, wnr_q, hit_q, snp_ack_sel, timeout_hit;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q, snp_data_sel;
  logic [NUM_CORES-1:0] arb_req;
  assign other = ~winner;
  assign snp_ack_sel = snp_ack_i[other];
  assign snp_data_sel = other ? snp_data_i[DATA_W +: DATA_W] : snp_data_i[0 +: DATA_W];
  // In RESP the arbiter sees only the winner, so advancing hands the token to the other core
  assign arb_req = (state == RESP) ? {winner, ~winner} : req_valid_i;
  snoopy_token_rr u_arb (
    .req        (arb_req),
    .token      (token),
    .advance    (state == RESP),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .token_nxt  (token_nxt)
  );
`ifdef SNOOPY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic to_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      to_q <= 1'b0;
    end else begin
      cnt <= (state == SNOOP) ? cnt + CW'(1) : '0;
      if (state == SNOOP) to_q <= timeout_hit;
    end
  end
  assign timeout_hit = (state == SNOOP) && !snp_ack_sel && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_o = (state == RESP) && to_q;
`else
  logic unused_to;
  assign unused_to = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      token <= 1'b0;
      winner <= 1'b0;
      addr_q <= '0;
      wnr_q <= 1'b0;
      hit_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      token <= token_nxt;
      if (state == IDLE && grant_valid) begin
        winner <= grant_id;
        addr_q <= grant_id ? req_addr_i[ADDR_W +: ADDR_W] : req_addr_i[0 +: ADDR_W];
        wnr_q <= req_wnr_i[grant_id];
      end
      if (state == SNOOP && (snp_ack_sel || timeout_hit)) begin
        hit_q <= snp_ack_sel && snp_hit_i[other];
        data_q <= (snp_ack_sel && !wnr_q) ? snp_data_sel : '0;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    snp_valid_o = '0;
    req_ack_o = '0;
    rsp_hit_o = 1'b0;
    rsp_data_o = '0;
    case (state)
      IDLE: state_nxt = grant_valid ? SNOOP : IDLE;
      SNOOP: begin
        snp_valid_o[other] = 1'b1;
        state_nxt = (snp_ack_sel || timeout_hit) ? RESP : SNOOP;
      end
      RESP: begin
        req_ack_o[winner] = 1'b1;
        rsp_hit_o = hit_q;
        rsp_data_o = data_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign snp_wnr_o = wnr_q;
  assign snp_addr_o = addr_q;
  assign token_o = token;
  assign busy_o = (state != IDLE);
endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// tb_snoopy_bus_arbiter: scoreboard bench for snoopy_bus_arbiter
module tb_snoopy_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_wnr = '0, snp_ack = '0, snp_hit = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] snp_data = '0;
  logic [1:0] req_ack_o, snp_valid_o;
  logic rsp_hit_o, snp_wnr_o, token_o, busy_o, timeout_o;
  logic [DW-1:0] rsp_data_o;
  logic [AW-1:0] snp_addr_o;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [1:0]    ack;
    logic          hit;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  snoopy_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_wnr_i(req_wnr), .req_addr_i(req_addr),
    .req_ack_o(req_ack_o), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o),
    .snp_valid_o(snp_valid_o), .snp_wnr_o(snp_wnr_o), .snp_addr_o(snp_addr_o),
    .snp_ack_i(snp_ack), .snp_hit_i(snp_hit), .snp_data_i(snp_data),
    .token_o(token_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && req_ack_o != 2'b00) begin
      if (sb.size() == 0) check("unexpected_ack", {62'b0, req_ack_o}, 64'd0);
      else begin
        mon_e = sb.pop_front();
        check("rsp_ack", req_ack_o, mon_e.ack);
        check("rsp_hit", rsp_hit_o, mon_e.hit);
        check("rsp_data", rsp_data_o, mon_e.data);
        check("rsp_timeout", timeout_o, mon_e.to);
      end
    end
  end

  task automatic issue(input int c, input logic w, input logic [AW-1:0] a);
    req_valid[c] = 1'b1;
    req_wnr[c] = w;
    req_addr[c*AW +: AW] = a;
  endtask

  task automatic wait_snp(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (snp_valid_o != 2'b00);
    end
    if (!ok) check("snp_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (req_ack_o != 2'b00);
    end
    if (!ok) check("ack_wait", 64'd0, 64'd1);
  endtask

  task automatic serve(input int c, input logic w, input logic [AW-1:0] a, input int lat,
                       input logic h, input logic [DW-1:0] d);
    bit ok;
    logic [34:0] hold;
    hold = {2'(1 << (1 - c)), w, a};
    sb.push_back('{ack: 2'(1 << c), hit: h, data: (w ? '0 : d), to: 1'b0});
    wait_snp(ok);
    check("snp_first", {snp_valid_o, snp_wnr_o, snp_addr_o}, hold);
    repeat (lat) begin
      @(negedge clk);
      check("snp_hold", {timeout_o, snp_valid_o, snp_wnr_o, snp_addr_o}, {1'b0, hold});
    end
    snp_ack[1-c] = 1'b1;
    snp_hit[1-c] = h;
    snp_data[(1-c)*DW +: DW] = d;
    wait_ack(ok);
    req_valid[c] = 1'b0;
    snp_ack = '0;
    snp_hit = '0;
    snp_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_ctl", {req_ack_o, snp_valid_o, token_o, busy_o, timeout_o, rsp_hit_o}, 64'd0);
    check("rst_data", rsp_data_o, 64'd0);
    check("rst_snp", {snp_wnr_o, snp_addr_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctl", {req_ack_o, snp_valid_o, token_o, busy_o}, 64'd0);
    // core0 read, token 0, ack 3 cycles after strobe
    issue(0, 1'b0, 32'h0000_0100);
    serve(0, 1'b0, 32'h0000_0100, 3, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("tok_t1", token_o, 64'd1);
    check("idle_t1", busy_o, 64'd0);
    // core1 write-invalidate, data must come back 0
    issue(1, 1'b1, 32'h0000_0200);
    serve(1, 1'b1, 32'h0000_0200, 2, 1'b0, 32'h0000_1234);
    @(negedge clk);
    check("tok_t3", token_o, 64'd0);
    // simultaneous requests, token 0: core0 then core1
    issue(0, 1'b0, 32'h0000_0100);
    issue(1, 1'b1, 32'h0000_0200);
    serve(0, 1'b0, 32'h0000_0100, 1, 1'b1, 32'hA5A5_0001);
    serve(1, 1'b1, 32'h0000_0200, 0, 1'b1, 32'hCAFE_0002);
    @(negedge clk);
    check("tok_t2", token_o, 64'd0);
    // stray acks in IDLE and from the requester are ignored
    snp_ack = 2'b11;
    snp_hit = 2'b11;
    snp_data = {32'h1111_1111, 32'h2222_2222};
    repeat (2) begin
      @(negedge clk);
      check("stray_idle", {busy_o, snp_valid_o}, 64'd0);
    end
    snp_ack = 2'b01;
    snp_hit = 2'b01;
    snp_data = {32'h0, 32'h2222_2222};
    issue(0, 1'b0, 32'h0000_0300);
    serve(0, 1'b0, 32'h0000_0300, 4, 1'b0, 32'h0000_0055);
    @(negedge clk);
    check("tok_t5", token_o, 64'd1);
    // async reset two cycles into SNOOP
    issue(1, 1'b0, 32'h0000_0400);
    wait_snp(ok);
    check("t4_snp", snp_valid_o, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t4_rst", {req_ack_o, snp_valid_o, busy_o, token_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(1, 1'b0, 32'h0000_0400, 1, 1'b1, 32'h0BAD_F00D);
    @(negedge clk);
    check("tok_t4", token_o, 64'd0);
`ifdef SNOOPY_TIMEOUT_EN
    begin
      int k;
      snp_hit = 2'b11;
      snp_data = {32'h7777_7777, 32'h8888_8888};
      issue(0, 1'b0, 32'h0000_0500);
      sb.push_back('{ack: 2'b01, hit: 1'b0, data: '0, to: 1'b1});
      wait_snp(ok);
      k = 0;
      for (int i = 1; i <= 40 && k == 0; i++) begin
        @(negedge clk);
        if (req_ack_o != 2'b00) k = i;
      end
      check("t6_latency", k, 64'd16);
      req_valid = '0;
      snp_hit = '0;
      snp_data = '0;
    end
`else
    issue(0, 1'b0, 32'h0000_0500);
    serve(0, 1'b0, 32'h0000_0500, 20, 1'b1, 32'h0000_600D);
`endif
    @(negedge clk);
    check("tok_t6", token_o, 64'd1);
    check("sb_empty", sb.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
